multi_player_move_ctrl: RTL and testbench

MULTI_PLAYER_MOVE_CTRL -- requirements
Module: multi_player_move_ctrl

---
 rtl/game_ctrl_pkg.sv | 87 ++++++++
 rtl/move_queue.sv | 63 ++++++
 rtl/multi_player_move_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multi_player_move_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the multi-player move controller: FSM states, move directions,
// PS/2 prefix bytes and the per-player keycode table.
package game_ctrl_pkg;

    typedef enum logic [3:0] {
        StStartScreen,
        StWaitLevel,
        StClearScreen,
        StDrawMaze,
        StDrawSpecial,
        StIdle,
        StEraseOld,
        StCheck,
        StCommit,
        StDrawNew
    } state_e;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } dir_e;

    localparam logic [7:0] CodeExt = 8'hE0;
    localparam logic [7:0] CodeBrk = 8'hF0;

    localparam int unsigned MaxPlayers = 4;

    // Indexed [player][dir]; each row lists right, left, down, up.
    localparam logic [3:0][3:0][7:0] KeyCode = {
        {8'h74, 8'h6B, 8'h73, 8'h75},  // P3 numpad 6/4/5/8
        {8'h4B, 8'h3B, 8'h42, 8'h43},  // P2 L/J/K/I
        {8'h74, 8'h6B, 8'h72, 8'h75},  // P1 arrows
        {8'h23, 8'h1C, 8'h1B, 8'h1D}   // P0 D/A/S/W
    };

    // Only the arrow keys carry the E0 prefix.
    localparam logic [3:0] KeyIsExt = 4'b0010;

    typedef struct packed {
        logic       hit;
        logic [1:0] player;
        dir_e       dir;
    } key_move_t;

    typedef struct packed {
        logic draw_start;
        logic draw_clear;
        logic draw_maze;
        logic draw_special;
        logic erase_box;
        logic check_move;
        logic commit_move;
        logic draw_box;
    } cmd_t;

    function automatic key_move_t decode_key(input logic [7:0] code, input logic ext);
        key_move_t m;
        m = '{hit: 1'b0, player: 2'd0, dir: DirUp};
        for (int p = 0; p < MaxPlayers; p++) begin
            for (int d = 0; d < 4; d++) begin
                if (ext == KeyIsExt[p] && code == KeyCode[p][d]) begin
                    m.hit    = 1'b1;
                    m.player = 2'(p);
                    m.dir    = dir_e'(2'(d));
                end
            end
        end
        return m;
    endfunction

    function automatic cmd_t state_cmds(input state_e st);
        cmd_t c;
        c              = '0;
        c.draw_start   = (st == StStartScreen);
        c.draw_clear   = (st == StClearScreen);
        c.draw_maze    = (st == StDrawMaze);
        c.draw_special = (st == StDrawSpecial);
        c.erase_box    = (st == StEraseOld);
        c.check_move   = (st == StCheck);
        c.commit_move  = (st == StCommit);
        c.draw_box     = (st == StDrawNew);
        return c;
    endfunction

endpackage

// File: rtl/move_queue.sv
// First-word-fall-through FIFO of pending moves. A pop frees a slot for a push in the same
// cycle, so a simultaneous push and pop is accepted even when full.
module move_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic [AddrW:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AddrW + 1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/multi_player_move_ctrl.sv
// Game controller: decodes PS/2 bytes into per-player moves, buffers them, and sequences the
// renderer and legality checker through screen setup and one move at a time.
module multi_player_move_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned LEVEL_W     = 3,
    localparam int unsigned PlayerW    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               external_reset,
    input  logic [LEVEL_W-1:0] level_sw,
    input  logic               rx_en,
    input  logic [7:0]         rx_data,
    input  logic               done_screen,
    input  logic               done_maze,
    input  logic               done_special,
    input  logic               done_erase,
    input  logic               done_check,
    input  logic               is_legal,
    input  logic               done_draw,
    output logic               draw_start,
    output logic               draw_clear,
    output logic               draw_maze,
    output logic               draw_special,
    output logic               erase_box,
    output logic               check_move,
    output logic               commit_move,
    output logic               draw_box,
    output logic [PlayerW-1:0] move_player,
    output logic [1:0]         move_dir,
    output logic [LEVEL_W-1:0] level_q,
    output logic               drop_pulse
);

    localparam int unsigned QueueW = PlayerW + 2;

    state_e    state_q;
    state_e    state_d;
    cmd_t      cmd_q;
    logic      ext_q;
    logic      brk_q;
    key_move_t key;
    logic      byte_done;
    logic      key_req;
    logic      accepting;
    logic      force_start;
    logic      q_flush;
    logic      q_push;
    logic      q_pop;
    logic      q_full;
    logic      q_empty;
    logic [QueueW-1:0] q_din;
    logic [QueueW-1:0] q_dout;

    assign key       = decode_key(rx_data, ext_q);
    assign byte_done = rx_en && (rx_data != CodeExt) && (rx_data != CodeBrk);
    assign key_req   = byte_done && !brk_q && key.hit && (32'(key.player) < NUM_PLAYERS);
    assign q_din     = {key.player[PlayerW-1:0], key.dir};

    assign accepting   = state_q inside {StIdle, StEraseOld, StCheck, StCommit, StDrawNew};
    // Once a level is chosen, dropping the switch back to zero aborts the game.
    assign force_start = !(state_q inside {StStartScreen, StWaitLevel}) && (level_sw == '0);
    assign q_flush     = external_reset || force_start || !accepting;
    assign q_pop       = (state_q == StIdle) && !q_empty && !q_flush;
    assign q_push      = key_req && !q_flush;

    move_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (QueueW)
    ) u_move_queue (
        .clock  (clock),
        .resetn (resetn),
        .push   (q_push),
        .pop    (q_pop),
        .flush  (q_flush),
        .din    (q_din),
        .dout   (q_dout),
        .full   (q_full),
        .empty  (q_empty)
    );

    always_comb begin
        state_d = state_q;
        if (external_reset || force_start) begin
            state_d = StStartScreen;
        end else begin
            unique case (state_q)
                StStartScreen: if (done_screen)      state_d = StWaitLevel;
                StWaitLevel:   if (level_sw != '0)   state_d = StClearScreen;
                StClearScreen: if (done_screen)      state_d = StDrawMaze;
                StDrawMaze:    if (done_maze)        state_d = StDrawSpecial;
                StDrawSpecial: if (done_special)     state_d = StIdle;
                StIdle:        if (q_pop)            state_d = StEraseOld;
                StEraseOld:    if (done_erase)       state_d = StCheck;
                StCheck: begin
                    if (done_check) begin
                        state_d = is_legal ? StCommit : StDrawNew;
                    end
                end
                StCommit:                            state_d = StDrawNew;
                StDrawNew:     if (done_draw)        state_d = StIdle;
                default:                             state_d = StStartScreen;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StStartScreen;
            cmd_q       <= state_cmds(StStartScreen);
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            move_player <= '0;
            move_dir    <= '0;
            level_q     <= '0;
            drop_pulse  <= 1'b0;
        end else if (external_reset) begin
            state_q     <= StStartScreen;
            cmd_q       <= state_cmds(StStartScreen);
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            move_player <= '0;
            move_dir    <= '0;
            level_q     <= '0;
            drop_pulse  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= state_cmds(state_d);
            drop_pulse <= key_req && !q_flush && q_full && !q_pop;
            if (rx_en) begin
                if (rx_data == CodeExt) begin
                    ext_q <= 1'b1;
                end else if (rx_data == CodeBrk) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
            if (q_pop) begin
                move_player <= q_dout[QueueW-1:2];
                move_dir    <= q_dout[1:0];
            end
            if (state_q == StWaitLevel && state_d == StClearScreen) begin
                level_q <= level_sw;
            end
        end
    end

    assign draw_start   = cmd_q.draw_start;
    assign draw_clear   = cmd_q.draw_clear;
    assign draw_maze    = cmd_q.draw_maze;
    assign draw_special = cmd_q.draw_special;
    assign erase_box    = cmd_q.erase_box;
    assign check_move   = cmd_q.check_move;
    assign commit_move  = cmd_q.commit_move;
    assign draw_box     = cmd_q.draw_box;

endmodule

// File: tb/tb_multi_player_move_ctrl.sv
// Bench for multi_player_move_ctrl: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a queue-based game model.
module tb_multi_player_move_ctrl;

    localparam int unsigned NP = 3;
    localparam int unsigned QD = 4;
    localparam int unsigned LW = 3;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          external_reset = 1'b0;
    logic [LW-1:0] level_sw = '0;
    logic          rx_en = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          done_screen = 1'b0, done_maze = 1'b0, done_special = 1'b0;
    logic          done_erase = 1'b0, done_check = 1'b0, is_legal = 1'b0, done_draw = 1'b0;
    logic          draw_start, draw_clear, draw_maze, draw_special;
    logic          erase_box, check_move, commit_move, draw_box;
    logic [1:0]    move_player;
    logic [1:0]    move_dir;
    logic [LW-1:0] level_q;
    logic          drop_pulse;
    logic [7:0]    cmds;

    int checks = 0;
    int errors = 0;
    int drops = 0;
    int commits = 0;
    bit cmp_en = 1'b0;

    multi_player_move_ctrl #(
        .NUM_PLAYERS (NP),
        .QUEUE_DEPTH (QD),
        .LEVEL_W     (LW)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .external_reset (external_reset),
        .level_sw       (level_sw),
        .rx_en          (rx_en),
        .rx_data        (rx_data),
        .done_screen    (done_screen),
        .done_maze      (done_maze),
        .done_special   (done_special),
        .done_erase     (done_erase),
        .done_check     (done_check),
        .is_legal       (is_legal),
        .done_draw      (done_draw),
        .draw_start     (draw_start),
        .draw_clear     (draw_clear),
        .draw_maze      (draw_maze),
        .draw_special   (draw_special),
        .erase_box      (erase_box),
        .check_move     (check_move),
        .commit_move    (commit_move),
        .draw_box       (draw_box),
        .move_player    (move_player),
        .move_dir       (move_dir),
        .level_q        (level_q),
        .drop_pulse     (drop_pulse)
    );

    always #5 clock = ~clock;

    assign cmds = {draw_start, draw_clear, draw_maze, draw_special,
                   erase_box, check_move, commit_move, draw_box};

    // ---------------- behavioural model ----------------
    localparam int PhStart = 0, PhWait = 1, PhClear = 2, PhMaze = 3, PhSpecial = 4;
    localparam int PhIdle = 5, PhErase = 6, PhCheck = 7, PhCommit = 8, PhDraw = 9;

    int m_ph = PhStart;
    bit m_ext = 1'b0, m_brk = 1'b0, m_drop = 1'b0;
    int m_q[$];
    int m_player = 0, m_dir = 0, m_level = 0;

    // Move as player*4+dir, or -1 when the code is not a usable make code.
    function automatic int key_move(input logic [7:0] b, input bit ext);
        int mv;
        case ({ext, b})
            9'h01D: mv = 0;  9'h01B: mv = 1;  9'h01C: mv = 2;  9'h023: mv = 3;
            9'h175: mv = 4;  9'h172: mv = 5;  9'h16B: mv = 6;  9'h174: mv = 7;
            9'h043: mv = 8;  9'h042: mv = 9;  9'h03B: mv = 10; 9'h04B: mv = 11;
            9'h075: mv = 12; 9'h073: mv = 13; 9'h06B: mv = 14; 9'h074: mv = 15;
            default: mv = -1;
        endcase
        if (mv >= 0 && mv / 4 >= int'(NP)) mv = -1;
        return mv;
    endfunction

    task automatic m_reset();
        m_ph = PhStart; m_ext = 0; m_brk = 0; m_drop = 0;
        m_q.delete(); m_player = 0; m_dir = 0; m_level = 0;
    endtask

    task automatic m_step();
        int  mv = -1;
        int  head;
        bit  force_st, pop;
        if (external_reset) begin
            m_reset();
            return;
        end
        if (rx_en) begin
            if (rx_data == 8'hE0) m_ext = 1;
            else if (rx_data == 8'hF0) m_brk = 1;
            else begin
                if (!m_brk) mv = key_move(rx_data, m_ext);
                m_ext = 0;
                m_brk = 0;
            end
        end
        force_st = (m_ph >= PhClear) && (level_sw == 0);
        pop = (m_ph == PhIdle) && (m_q.size() > 0) && !force_st;
        m_drop = 0;
        if (pop) begin
            head = m_q.pop_front();
            m_player = head / 4;
            m_dir = head % 4;
        end
        if (m_ph < PhIdle || force_st) m_q.delete();
        else if (mv >= 0) begin
            if (m_q.size() < int'(QD)) m_q.push_back(mv);
            else m_drop = 1;
        end
        if (force_st) m_ph = PhStart;
        else begin
            case (m_ph)
                PhStart:   if (done_screen) m_ph = PhWait;
                PhWait:    if (level_sw != 0) begin m_level = level_sw; m_ph = PhClear; end
                PhClear:   if (done_screen) m_ph = PhMaze;
                PhMaze:    if (done_maze) m_ph = PhSpecial;
                PhSpecial: if (done_special) m_ph = PhIdle;
                PhIdle:    if (pop) m_ph = PhErase;
                PhErase:   if (done_erase) m_ph = PhCheck;
                PhCheck:   if (done_check) m_ph = is_legal ? PhCommit : PhDraw;
                PhCommit:  m_ph = PhDraw;
                PhDraw:    if (done_draw) m_ph = PhIdle;
                default:   m_ph = PhStart;
            endcase
        end
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) m_reset();
        else m_step();
    end

    function automatic logic [7:0] ph_cmds(input int ph);
        logic [7:0] c;
        c = '0;
        case (ph)
            PhStart:   c = 8'b1000_0000;
            PhClear:   c = 8'b0100_0000;
            PhMaze:    c = 8'b0010_0000;
            PhSpecial: c = 8'b0001_0000;
            PhErase:   c = 8'b0000_1000;
            PhCheck:   c = 8'b0000_0100;
            PhCommit:  c = 8'b0000_0010;
            PhDraw:    c = 8'b0000_0001;
            default:   c = 8'b0000_0000;
        endcase
        return c;
    endfunction

    always @(negedge clock) begin
        logic [15:0] got, exp;
        if (cmp_en) begin
            got = {cmds, move_player, move_dir, level_q, drop_pulse};
            exp = {ph_cmds(m_ph), 2'(m_player), 2'(m_dir), 3'(m_level), m_drop};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL model t=%0t cmds/player/dir/level/drop got=%b required=%b",
                         $time, got, exp);
            end
            if (drop_pulse === 1'b1) drops++;
            if (commit_move === 1'b1) commits++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_en = 1'b1;
        rx_data = b;
        tick();
        rx_en = 1'b0;
    endtask

    task automatic pulse(input int which);
        case (which)
            0: done_screen = 1'b1;
            1: done_maze = 1'b1;
            2: done_special = 1'b1;
            3: done_erase = 1'b1;
            default: done_draw = 1'b1;
        endcase
        tick();
        {done_screen, done_maze, done_special, done_erase, done_draw} = '0;
    endtask

    task automatic wait_cmd(input string name, input int bitpos, input int budget);
        int n = 0;
        while (cmds[bitpos] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, required command never seen", name, n);
        end
    endtask

    task automatic to_idle(input logic [LW-1:0] lvl);
        pulse(0);
        level_sw = lvl;
        tick();
        pulse(0);
        pulse(1);
        pulse(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B,
                              8'h72, 8'h74, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h73, 8'h74};
    int exp_p [4] = '{0, 0, 0, 1};
    int exp_d [4] = '{2, 1, 3, 2};

    initial begin
        int d0;
        repeat (3) tick();
        cmp_en = 1'b1;
        resetn = 1'b1;
        tick();
        chk("reset cmds", cmds, 8'h80);
        chk("reset move_player", move_player, 0);
        chk("reset level_q", level_q, 0);

        // setup to IDLE with level 2
        pulse(0);
        chk("wait_level cmds", cmds, 8'h00);
        level_sw = 3'b010;
        tick();
        chk("clear_screen cmds", cmds, 8'h40);
        chk("level latched", level_q, 2);
        pulse(0);
        pulse(1);
        pulse(2);
        chk("idle cmds", cmds, 8'h00);
        level_sw = 3'b101;
        tick();
        chk("level ignores change", level_q, 2);

        // arrow up for player 1, latency and commit
        send(8'hE0);
        send(8'h75);
        chk("erase at N+1", erase_box, 0);
        tick();
        chk("erase at N+2", erase_box, 1);
        chk("arrow player", move_player, 1);
        chk("arrow dir", move_dir, 0);
        pulse(3);
        chk("check_move", check_move, 1);
        done_check = 1'b1; is_legal = 1'b1;
        tick();
        done_check = 1'b0; is_legal = 1'b0;
        chk("commit pulse", commit_move, 1);
        tick();
        chk("commit one cycle", commit_move, 0);
        chk("draw after commit", draw_box, 1);
        pulse(5);
        chk("commit count 1", commits, 1);

        // break code: no move
        send(8'hF0);
        send(8'h1D);
        for (int i = 0; i < 4; i++) begin
            chk("no move on break", cmds, 8'h00);
            tick();
        end

        // fill queue while held in CHECK
        send(8'h1D);
        tick();
        pulse(3);
        d0 = drops;
        send(8'h1C);
        send(8'h1B);
        send(8'h23);
        send(8'hE0);
        send(8'h6B);
        send(8'h43);
        tick();
        chk("one drop", drops - d0, 1);
        chk("still in check", check_move, 1);
        done_check = 1'b1; is_legal = 1'b1;
        tick();
        done_check = 1'b0; is_legal = 1'b0;
        wait_cmd("held move draw", 0, 10);
        pulse(5);
        for (int i = 0; i < 4; i++) begin
            wait_cmd("serve erase", 3, 10);
            chk("served player", move_player, exp_p[i]);
            chk("served dir", move_dir, exp_d[i]);
            pulse(3);
            done_check = 1'b1;
            is_legal = (i != 3);
            tick();
            done_check = 1'b0; is_legal = 1'b0;
            if (i == 3) begin
                chk("illegal no commit", commit_move, 0);
                chk("illegal draws", draw_box, 1);
            end
            wait_cmd("serve draw", 0, 10);
            pulse(5);
        end
        for (int i = 0; i < 4; i++) begin
            chk("queue drained", erase_box, 0);
            tick();
        end
        chk("commit count 5", commits, 5);

        // level switch to zero mid DRAW_NEW
        send(8'h1D);
        send(8'h1B);
        tick();
        pulse(3);
        done_check = 1'b1; is_legal = 1'b1;
        tick();
        done_check = 1'b0; is_legal = 1'b0;
        tick();
        chk("in draw_new", draw_box, 1);
        level_sw = '0;
        tick();
        chk("abort to start", cmds, 8'h80);
        to_idle(3'b011);
        chk("relatched level", level_q, 3);
        for (int i = 0; i < 5; i++) begin
            chk("queue flushed", erase_box, 0);
            tick();
        end

        // synchronous restart abandons the move
        send(8'h23);
        tick();
        pulse(3);
        done_check = 1'b1; is_legal = 1'b1; external_reset = 1'b1;
        tick();
        done_check = 1'b0; is_legal = 1'b0; external_reset = 1'b0;
        chk("ext reset cmds", cmds, 8'h80);
        chk("ext reset dir", move_dir, 0);
        chk("ext reset level", level_q, 0);
        tick();
        chk("ext reset no commit", commit_move, 0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            int k;
            rx_en = ($urandom_range(0, 2) == 0);
            k = $urandom_range(0, 16);
            rx_data = (k == 16) ? 8'($urandom) : pool[k];
            done_screen  = ($urandom_range(0, 2) == 0);
            done_maze    = ($urandom_range(0, 2) == 0);
            done_special = ($urandom_range(0, 2) == 0);
            done_erase   = ($urandom_range(0, 2) == 0);
            done_check   = ($urandom_range(0, 2) == 0);
            done_draw    = ($urandom_range(0, 2) == 0);
            is_legal     = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 299) == 0) level_sw = '0;
            else if (level_sw == '0 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0))
                level_sw = 3'($urandom_range(1, 7));
            external_reset = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 1499) == 0) resetn = 1'b0;
            tick();
            resetn = 1'b1;
        end
        rx_en = 1'b0;
        external_reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
